if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It holds the program counter and issues requests to the instruction memory over a ready handshake. It splits each 16-bit instruction word into opcode/rd/r1/r2 fields that feed the IF/ID register inputs. When no valid instruction is available (wait state, stall, branch redirect, reset) it emits the NOP encoding: opcode 5'h1f, all address fields 0.

Parameters:
PC_W, 8, program counter / instruction memory address width
RESET_PC, 0, PC value loaded on reset (PC_W bits)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_W  fetch address, equals pc
imem_rdata  in  16  instruction word, valid when imem_ready=1
imem_ready  in  1  memory returns imem_rdata this cycle; ignored when imem_req=0
stall  in  1  downstream hazard; fetch stage must issue bubbles
branch_taken  in  1  redirect pulse from execute
branch_target  in  PC_W  redirect address
inst_opcode  out  5  to IF/ID INST_OPCODE
inst_rd_addr  out  3  to IF/ID INST_RD_ADDR
inst_r1_addr  out  4  to IF/ID INST_R1_ADDR
inst_r2_addr  out  4  to IF/ID INST_R2_ADDR
inst_valid  out  1  1 = fields hold a real instruction, 0 = NOP bubble
pc_out  out  PC_W  address of the instruction currently on inst_* (0 when bubble)

Behaviour:
- Field split: opcode=[15:11], rd=[10:8], r1=[7:4], r2=[3:0].
- All inst_* / inst_valid / pc_out are registered. Reset values: opcode 5'h1f, others 0, inst_valid 0, pc_out 0. On reset, pc=RESET_PC, hold buffer empty, state FETCH. imem_req is 0 during the reset cycle.
- States:
  - FETCH: imem_req = !stall && !branch_taken; imem_addr = pc.
  - HOLD: an instruction is buffered; imem_req = 0.
- Per-edge priority, highest first:
  1. rst.
  2. branch_taken: pc <= branch_target; hold buffer cleared; state <= FETCH; outputs <= NOP; any imem_ready this cycle is discarded.
  3. FETCH && imem_ready && imem_req && !stall: outputs <= decoded imem_rdata, inst_valid 1, pc_out <= pc; pc <= pc+1.
  4. HOLD && !stall: outputs <= hold buffer, inst_valid 1; state <= FETCH.
  5. Otherwise: outputs <= NOP, inst_valid 0.
- Since imem_req=0 whenever stall=1 in FETCH, no response arrives while stalled. Memory must not return data for a request it saw deasserted. Therefore HOLD is entered only under the optional prefetch feature; in the base build HOLD is unreachable.
- Latency: a request answered in cycle N (imem_ready=1) appears on inst_* after the edge ending N, i.e. 1 cycle. Zero-wait memory gives one instruction per cycle.
- Wrap-around: pc increments modulo 2^PC_W; pc=all-ones followed by 0.
- Wait states: while imem_req=1 and imem_ready=0, pc is held and NOP is emitted every cycle.
- Stall and branch together: branch wins; stall then only suppresses the request on the next cycles.
- Reset mid-request: the in-flight response is ignored, and the memory must drop it.

Optional Feature:
Macro IF_PREFETCH_EN.
- Defined: imem_req stays 1 in FETCH during stall (still 0 when branch_taken). A response arriving while stall=1 is captured into the 16-bit hold buffer with its pc; pc <= pc+1; state <= HOLD; outputs NOP. The first non-stall cycle in HOLD releases the buffer (rule 4). A branch in HOLD discards the buffer.
- Not defined: no hold buffer, HOLD state absent, behaviour exactly as in the base rules.

Test Plan:
- Reset, then imem always ready, rdata = 16'hF800 + addr -> after rst drops, inst_valid rises 1 cycle after the first req; pc_out sequence 0,1,2…; opcode 5'h1f, rd 0, r1 = addr[7:4], r2 = addr[3:0].
- imem_ready low 3 cycles on addr 5 -> three NOP cycles (opcode 1f, valid 0), imem_addr held at 5, then instruction 5 appears once.
- branch_taken with target 8'h40 while a fetch at addr 7 is in flight and ready in the same cycle -> instruction 7 dropped, next output NOP, next fetch address 8'h40.
- stall high 2 cycles at pc 3 -> imem_req 0, two NOP outputs, no pc change. With IF_PREFETCH_EN: instruction 3 is buffered and emitted on the first cycle after stall drops, then pc 4 follows.
- PC_W=4, run from pc 14 -> addresses 14,15,0,1 and pc_out matches.
- rst asserted while imem_req=1 and imem_ready=0 -> next cycle outputs NOP, pc=RESET_PC, and a late imem_ready is ignored.

Source files
------------

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage feeding the IF/ID register (optional prefetch: IF_PREFETCH_EN)
module if_fetch_stage #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [4:0]      inst_opcode,
  output logic [2:0]      inst_rd_addr,
  output logic [3:0]      inst_r1_addr,
  output logic [3:0]      inst_r2_addr,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc_out
);

  localparam logic [4:0] NOP_OPCODE = 5'h1f;

  logic [PC_W-1:0] pc;

`ifdef IF_PREFETCH_EN
  typedef enum logic {FETCH, HOLD} state_t;
  state_t          state;
  logic [15:0]     hold_inst;
  logic [PC_W-1:0] hold_pc;

  // Prefetch keeps requesting through a stall; a buffered word blocks new requests.
  assign imem_req = !rst && (state == FETCH) && !branch_taken;
`else
  assign imem_req = !rst && !stall && !branch_taken;
`endif

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      inst_opcode  <= NOP_OPCODE;
      inst_rd_addr <= '0;
      inst_r1_addr <= '0;
      inst_r2_addr <= '0;
      inst_valid   <= 1'b0;
      pc_out       <= '0;
`ifdef IF_PREFETCH_EN
      state        <= FETCH;
      hold_inst    <= '0;
      hold_pc      <= '0;
`endif
    end else begin
      inst_opcode  <= NOP_OPCODE;
      inst_rd_addr <= '0;
      inst_r1_addr <= '0;
      inst_r2_addr <= '0;
      inst_valid   <= 1'b0;
      pc_out       <= '0;
      if (branch_taken) begin
        pc <= branch_target;
`ifdef IF_PREFETCH_EN
        state     <= FETCH;
        hold_inst <= '0;
        hold_pc   <= '0;
`endif
      end else if (imem_req && imem_ready && !stall) begin
        // Field layout of the instruction word matches the output concatenation.
        {inst_opcode, inst_rd_addr, inst_r1_addr, inst_r2_addr} <= imem_rdata;
        inst_valid <= 1'b1;
        pc_out     <= pc;
        pc         <= pc + 1'b1;
`ifdef IF_PREFETCH_EN
      end else if (imem_req && imem_ready && stall) begin
        hold_inst <= imem_rdata;
        hold_pc   <= pc;
        pc        <= pc + 1'b1;
        state     <= HOLD;
      end else if ((state == HOLD) && !stall) begin
        {inst_opcode, inst_rd_addr, inst_r1_addr, inst_r2_addr} <= hold_inst;
        inst_valid <= 1'b1;
        pc_out     <= hold_pc;
        state      <= FETCH;
`endif
      end
    end
  end

endmodule
